nco_multi_ch: RTL

NCO_MULTI_CH -- requirements
Module: nco_multi_ch

---
 rtl/nco_multi_ch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/nco_multi_ch.sv
// nco_multi_ch: time-multiplexed multi-channel NCO with quarter-wave sin/cos LUT
module nco_multi_ch #(
   parameter int NCH = 4,
   parameter int APR = 32,
   parameter int MPR = 12,
   parameter int LAW = 10,
   parameter string LUT_FILE = "nco_multi_ch_sin_q.hex",
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clken,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CW-1:0]         cfg_ch,
   input  logic                  cfg_sel,
   input  logic [APR-1:0]        cfg_data,
   input  logic                  cfg_commit,
   input  logic                  sync_i,
   output logic                  out_valid,
   output logic [CW-1:0]         out_ch,
   output logic signed [MPR-1:0] fsin_o,
   output logic signed [MPR-1:0] fcos_o
);
   localparam int MW = MPR - 1;
   localparam int PW = LAW + 2;
   localparam int LN = 1 << LAW;

   // The quarter-wave table is computed in place; LUT_FILE names its equivalent hex image.
   if (NCH < 1 || NCH > 16 || APR < 16 || APR > 32 || MPR < 8 || MPR > 18 ||
       LAW < 6 || LAW > 12 || LAW + 2 > APR || LUT_FILE == "") begin : g_bad_param
      $error("nco_multi_ch: parameter out of range");
   end

   // round((2^MW-1)*sin((k+0.5)*pi/2^(LAW+1))) via Q30 Taylor series to x^13
   function automatic logic [MW-1:0] sin_q(input int k);
      longint x, x2, t;
      x = (longint'(2 * k + 1) * 64'sd3373259426 + (64'sd1 <<< (LAW + 1))) >>> (LAW + 2);
      x2 = (x * x) >>> 30;
      t = 64'sd1 <<< 30;
      for (int n = 6; n > 0; n--) t = (64'sd1 <<< 30) - ((x2 * t) >>> 30) / longint'(2 * n * (2 * n + 1));
      t = (x * t) >>> 30;
      return MW'((t * ((64'sd1 <<< MW) - 1) + (64'sd1 <<< 29)) >>> 30);
   endfunction

   logic [MW-1:0]  w_lut [LN];
   for (genvar i = 0; i < LN; i++) begin : g_lut
      assign w_lut[i] = sin_q(i);
   end

   logic [CW-1:0]  r_slot;
   logic [APR-1:0] r_acc [NCH];
   logic [APR-1:0] r_inc [NCH];
   logic [APR-1:0] r_off [NCH];
   logic [APR-1:0] r_sinc [NCH];
   logic [APR-1:0] r_soff [NCH];
   logic           r_cpend, r_spend, r_rdy;
   logic [PW-1:0]  r_ph1;
   logic [CW-1:0]  r_ch1, r_ch2, r_ch3;
   logic           r_v1, r_v2, r_v3, r_v4;
   logic [1:0]     r_q2;
   logic [LAW-1:0] r_as2, r_ac2;
   logic [MW-1:0]  r_ms3, r_mc3;
   logic           r_ns3, r_nc3;

   logic           w_fs, w_apply, w_sync, w_wr, w_last;
   logic [APR-1:0] w_acc, w_inc, w_off;

   assign w_fs      = clken & (r_slot == '0);
   assign w_apply   = w_fs & r_cpend;
   assign w_sync    = w_fs & r_spend;
   assign w_last    = r_slot == CW'(NCH - 1);
   assign cfg_ready = r_rdy & ~w_apply;
   assign w_wr      = cfg_valid & cfg_ready;
   // slot 0 of a committing frame reads the shadow copy directly, as the copy lands at this edge
   assign w_inc     = w_apply ? r_sinc[r_slot] : r_inc[r_slot];
   assign w_off     = w_apply ? r_soff[r_slot] : r_off[r_slot];
   assign w_acc     = w_sync ? '0 : r_acc[r_slot];
   assign out_valid = r_v4 & clken;

   // slot counter, accumulators, config staging/commit and pending flags
   always_ff @(posedge clk) begin
      if (reset) begin
         r_slot  <= '0;
         r_cpend <= 1'b0;
         r_spend <= 1'b0;
         r_rdy   <= 1'b0;
         for (int c = 0; c < NCH; c++) begin
            r_acc[c]  <= '0;
            r_inc[c]  <= '0;
            r_off[c]  <= '0;
            r_sinc[c] <= '0;
            r_soff[c] <= '0;
         end
      end else begin
         r_rdy   <= 1'b1;
         r_cpend <= ~w_apply & (r_cpend | cfg_commit);
         r_spend <= ~w_sync & (r_spend | sync_i);
         for (int c = 0; c < NCH; c++) begin
            if (w_apply) begin
               r_inc[c] <= r_sinc[c];
               r_off[c] <= r_soff[c];
            end
            if (w_sync && c != 0) r_acc[c] <= '0;
            if (w_wr && cfg_ch == CW'(c)) begin
               if (cfg_sel) r_soff[c] <= cfg_data;
               else r_sinc[c] <= cfg_data;
            end
         end
         if (clken) begin
            r_slot <= w_last ? '0 : r_slot + 1'b1;
            r_acc[r_slot] <= w_acc + w_inc;
         end
      end
   end

   // four-stage phase -> address -> LUT -> sign pipeline, frozen while clken is low
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_v4   <= 1'b0;
         out_ch <= '0;
         fsin_o <= '0;
         fcos_o <= '0;
      end else if (clken) begin
         r_v1   <= 1'b1;
         r_ch1  <= r_slot;
         r_ph1  <= PW'((w_acc + w_off) >> (APR - PW));
         r_v2   <= r_v1;
         r_ch2  <= r_ch1;
         r_q2   <= r_ph1[PW-1 -: 2];
         r_as2  <= r_ph1[LAW-1:0] ^ {LAW{r_ph1[LAW]}};
         r_ac2  <= r_ph1[LAW-1:0] ^ {LAW{~r_ph1[LAW]}};
         r_v3   <= r_v2;
         r_ch3  <= r_ch2;
         r_ms3  <= w_lut[r_as2];
         r_mc3  <= w_lut[r_ac2];
         r_ns3  <= r_q2[1];
         r_nc3  <= ^r_q2;
         r_v4   <= r_v3;
         out_ch <= r_ch3;
         fsin_o <= r_ns3 ? -$signed({1'b0, r_ms3}) : $signed({1'b0, r_ms3});
         fcos_o <= r_nc3 ? -$signed({1'b0, r_mc3}) : $signed({1'b0, r_mc3});
      end
   end
endmodule
